// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module     : matrix_pkg
// Description: Shared constants, state encoding and helpers for the matrix
//              result path (result RAM -> UART byte stream).
// Revision   : 1.0 - initial release
// ============================================================================
package matrix_pkg;

  localparam logic [3:0] HDR_TAG    = 4'hA;
  localparam int         MAX_N      = 15;
  localparam int         RES_ADDR_W = 8;
  localparam int         N_W        = $clog2(MAX_N + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SEND_HDR  = 4'd1,
    FETCH     = 4'd2,
    WAIT_RD   = 4'd3,
    SEND_HI   = 4'd4,
    SEND_LO   = 4'd5,
    SEND_CSUM = 4'd6,
    WAIT_TX   = 4'd7,
    FINISH    = 4'd8
  } state_t;

  // Frame header: tag nibble followed by the matrix dimension.
  function automatic logic [7:0] hdr_byte(input logic [N_W-1:0] n);
    return {HDR_TAG, n};
  endfunction

endpackage : matrix_pkg
`default_nettype wire

// File: rtl/result_sender.sv
`default_nettype none
// ============================================================================
// Module     : result_sender
// Description: Streams an N x N result matrix out of the result RAM as a
//              UART byte frame: header, MSB/LSB byte pairs, XOR checksum.
// Revision   : 1.0 - initial release
// ============================================================================
module result_sender
  import matrix_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_W-1:0]        matrix_size,
  output logic                  res_rd_en,
  output logic [RES_ADDR_W-1:0] res_addr,
  input  logic [15:0]           res_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  done
);

  state_t                  state, state_n;
  state_t                  ret_state, ret_n;
  logic                    skip_busy;
  logic [15:0]             word;
  logic [7:0]              csum;
  logic [RES_ADDR_W-1:0]   words_left;
  logic [RES_ADDR_W-1:0]   words_total;
  logic                    ld_hdr, ld_hi, ld_lo, ld_csum;
  logic                    last_word;

  // N*N deliberately kept to the address width; N=15 gives 225.
  assign words_total = RES_ADDR_W'(matrix_size) * RES_ADDR_W'(matrix_size);
  assign last_word   = (words_left == RES_ADDR_W'(1));

  // State register plus the state WAIT_TX hands control back to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ret_state <= IDLE;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
    end
  end

  // Next-state decode and the combinational strobes/pulses.
  always_comb begin
    state_n   = state;
    ret_n     = ret_state;
    tx_start  = 1'b0;
    res_rd_en = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE) && (state != FINISH);
    ld_hdr    = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    ld_csum   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND_HDR;
          ld_hdr  = 1'b1;
        end
      end
      SEND_HDR: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = WAIT_TX;
          ret_n    = (words_left == '0) ? SEND_CSUM : FETCH;
        end
      end
      FETCH: begin
        res_rd_en = 1'b1;
        state_n   = WAIT_RD;
      end
      WAIT_RD: begin
        state_n = SEND_HI;
        ld_hi   = 1'b1;
      end
      SEND_HI: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = WAIT_TX;
          ret_n    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = WAIT_TX;
          ret_n    = last_word ? SEND_CSUM : FETCH;
        end
      end
      SEND_CSUM: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = WAIT_TX;
          ret_n    = FINISH;
        end
      end
      WAIT_TX: begin
        // tx_busy only rises one cycle after tx_start, so skip that cycle.
        if (!skip_busy && !tx_busy) begin
          state_n = ret_state;
          ld_lo   = (ret_state == SEND_LO);
          ld_csum = (ret_state == SEND_CSUM);
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: outgoing byte, fetched word, running checksum, address/count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_busy  <= 1'b0;
      tx_data    <= '0;
      word       <= '0;
      csum       <= '0;
      res_addr   <= '0;
      words_left <= '0;
    end else begin
      skip_busy <= tx_start;
      // tx_data is loaded on entry to each SEND_* state and then held
      // untouched through WAIT_TX, so it is stable for the whole byte.
      if (ld_hdr) begin
        tx_data    <= hdr_byte(matrix_size);
        csum       <= '0;
        res_addr   <= '0;
        words_left <= words_total;
      end
      if (ld_hi) begin
        word    <= res_data;
        tx_data <= res_data[15:8];
      end
      if (ld_lo) begin
        tx_data <= word[7:0];
      end
      if (ld_csum) begin
        tx_data <= csum;
      end
      if (tx_start && (state != SEND_CSUM)) begin
        csum <= csum ^ tx_data;
      end
      if (tx_start && (state == SEND_LO)) begin
        words_left <= words_left - RES_ADDR_W'(1);
        res_addr   <= last_word ? '0 : res_addr + RES_ADDR_W'(1);
      end
    end
  end

endmodule : result_sender
`default_nettype wire

// File: tb/tb_result_sender.sv
`default_nettype none
// ============================================================================
// Module     : tb_result_sender
// Description: Directed self-checking bench for result_sender with a UART
//              busy model and a one-cycle-latency result RAM model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_result_sender;

  localparam int BUSY_CYC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  matrix_size = '0;
  logic        res_rd_en;
  logic [7:0]  res_addr;
  logic [15:0] res_data = '0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        done;

  logic [15:0] ram [256];
  int          busy_cnt = 0;
  logic        force_busy = 1'b0;

  logic [7:0]  bytes[$];
  logic [7:0]  exp_q[$];
  int          done_cnt, rd_cnt, dbl_cnt, max_addr;
  logic [7:0]  addr_at_done;
  logic        prev_ts;

  int vectors = 0;
  int miscompares = 0;

  result_sender dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_size (matrix_size),
    .res_rd_en   (res_rd_en),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0) || force_busy;

  // UART and RAM models.
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= BUSY_CYC;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (res_rd_en) res_data <= ram[res_addr];
  end

  // Observation of the output stream and pulses.
  always @(posedge clk) begin
    if (tx_start) bytes.push_back(tx_data);
    if (tx_start && prev_ts) dbl_cnt++;
    prev_ts = tx_start;
    if (done) begin
      done_cnt++;
      addr_at_done = res_addr;
    end
    if (res_rd_en) rd_cnt++;
    if (int'(res_addr) > max_addr) max_addr = int'(res_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bytes.delete();
    exp_q.delete();
    done_cnt = 0; rd_cnt = 0; dbl_cnt = 0; max_addr = 0;
    addr_at_done = 8'hEE;
    prev_ts = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] n);
    @(posedge clk); #1;
    start = 1'b1; matrix_size = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Expected frame: header, words MSB then LSB, XOR of everything before.
  task automatic build_exp(input int n);
    logic [7:0] x;
    exp_q.delete();
    exp_q.push_back({4'hA, 4'(n)});
    for (int i = 0; i < n * n; i++) begin
      exp_q.push_back(ram[i][15:8]);
      exp_q.push_back(ram[i][7:0]);
    end
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0 = done_cnt;
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > n0) break;
    end
    check({tag, "_timeout"}, (i < budget), 1);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, bytes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < bytes.size()) check($sformatf("%s_b%0d", tag, i), bytes[i], exp_q[i]);
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    clear_mon();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rd_en", res_rd_en, 0);
    check("rst_addr", res_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // N=2 basic frame; checksum of A2 12 34 00 FF AB CD 00 01 is 0x1C.
    ram[0] = 16'h1234; ram[1] = 16'h00FF; ram[2] = 16'hABCD; ram[3] = 16'h0001;
    clear_mon();
    pulse_start(4'd2);
    check("n2_busy", busy, 1);
    wait_done("n2", 2000);
    build_exp(2);
    compare_stream("n2");
    check("n2_csum_const", bytes.size() == 10 ? bytes[9] : 8'hXX, 8'h1C);
    check("n2_done_cnt", done_cnt, 1);
    check("n2_dbl", dbl_cnt, 0);
    check("n2_rd_cnt", rd_cnt, 4);
    check("n2_busy_after", busy, 0);

    // N=0: header and checksum only, no RAM reads.
    clear_mon();
    pulse_start(4'd0);
    wait_done("n0", 500);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA0);
    compare_stream("n0");
    check("n0_rd_cnt", rd_cnt, 0);
    check("n0_done_cnt", done_cnt, 1);

    // tx_busy held high: header must wait, then go out exactly once.
    clear_mon();
    force_busy = 1'b1;
    pulse_start(4'd0);
    repeat (50) @(posedge clk);
    #1;
    check("hold_no_start", bytes.size(), 0);
    force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_one_hdr", bytes.size(), 1);
    wait_done("hold", 500);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA0);
    compare_stream("hold");
    check("hold_dbl", dbl_cnt, 0);

    // Start re-pulsed mid-frame (N=3) must not disturb the frame.
    for (int i = 0; i < 9; i++) ram[i] = 16'(16'h1111 * (i + 1)) ^ 16'h0F30;
    clear_mon();
    pulse_start(4'd3);
    k = 0;
    while (bytes.size() < 3 && k < 1000) begin @(posedge clk); k++; end
    pulse_start(4'd5);
    wait_done("restart", 3000);
    build_exp(3);
    compare_stream("restart");
    check("restart_len20", bytes.size(), 20);
    check("restart_done", done_cnt, 1);

    // Reset after the 5th byte of an N=2 frame.
    ram[0] = 16'h1234; ram[1] = 16'h00FF; ram[2] = 16'hABCD; ram[3] = 16'h0001;
    clear_mon();
    pulse_start(4'd2);
    k = 0;
    while (bytes.size() < 5 && k < 1000) begin @(posedge clk); k++; end
    #3;
    rst = 1'b1;
    #1;
    check("mrst_tx_start", tx_start, 0);
    check("mrst_tx_data", tx_data, 0);
    check("mrst_rd_en", res_rd_en, 0);
    check("mrst_addr", res_addr, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("mrst_no_done", done_cnt, 0);
    check("mrst_no_more_bytes", bytes.size(), 5);
    clear_mon();
    ram[0] = 16'h5A5A;
    pulse_start(4'd1);
    wait_done("post_rst", 1000);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA1);
    compare_stream("post_rst");

    // N=15: 225 words, 452 bytes, addresses 0..224, back to 0 at done.
    for (int i = 0; i < 225; i++) ram[i] = 16'((i * 16'h0137) ^ 16'hC35A);
    clear_mon();
    pulse_start(4'd15);
    wait_done("n15", 20000);
    build_exp(15);
    compare_stream("n15");
    check("n15_len452", bytes.size(), 452);
    check("n15_max_addr", max_addr, 224);
    check("n15_addr_done", addr_at_done, 0);
    check("n15_rd_cnt", rd_cnt, 225);
    check("n15_done", done_cnt, 1);
    check("n15_dbl", dbl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_result_sender
`default_nettype wire
